jk_cmd_driver: RTL and testbench

Command sequencer that drives the J/K inputs of a bank of N JK flip-flops. It accepts set/clear/toggle/hold commands through a valid/ready handshake and converts each one into single-cycle J/K pulses on the selected bits; toggle commands can repeat with idle gaps between pulses. It also keeps a shadow copy of the expected flip-flop state for checking and readback. It sits directly upstream of the JK flip-flop bank; each J[i]/K[i] pair feeds one flip-flop on the same clock.

---
 rtl/jk_cmd_driver.sv | 119 +++++++++++
 tb/tb_jk_cmd_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: turns set/clear/toggle/hold commands into single-cycle J/K
// pulses for a bank of N JK flip-flops and keeps a shadow of the bank state.
// Toggle commands may repeat, with one idle cycle between pulses.
module jk_cmd_driver #(
   parameter int N  = 8,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [N-1:0]  cmd_mask,
   input  logic [RW-1:0] cmd_rep,
   output logic [N-1:0]  J,
   output logic [N-1:0]  K,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  q_model
);

   typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

   localparam logic [1:0] OP_HOLD   = 2'b00;
   localparam logic [1:0] OP_CLEAR  = 2'b01;
   localparam logic [1:0] OP_SET    = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   state_t        state_reg, state_next;
   logic [1:0]    op_reg, op_next;
   logic [N-1:0]  mask_reg, mask_next;
   // One bit wider than the repeat count so rep = 2^RW-1 (giving 2^RW pulses) fits.
   logic [RW:0]   rem_reg, rem_next;
   logic [N-1:0]  j_reg, j_next;
   logic [N-1:0]  k_reg, k_next;
   logic [N-1:0]  q_reg, q_next;
   logic          done_reg, done_next;

   // Next-state, latched-command and registered-output logic.
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      mask_next  = mask_reg;
      rem_next   = rem_reg;
      j_next     = '0;
      k_next     = '0;
      q_next     = q_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               op_next    = cmd_op;
               mask_next  = cmd_mask;
               rem_next   = (cmd_op == OP_TOGGLE) ? ({1'b0, cmd_rep} + (RW+1)'(1))
                                                  : (RW+1)'(1);
               state_next = DRIVE;
               // The op encoding is {J,K}, so each bit gates the mask directly.
               j_next     = cmd_op[1] ? cmd_mask : '0;
               k_next     = cmd_op[0] ? cmd_mask : '0;
            end
         end
         DRIVE: begin
            // The bank samples J/K at this edge; mirror its response on masked bits.
            case (op_reg)
               OP_CLEAR:  q_next = q_reg & ~mask_reg;
               OP_SET:    q_next = q_reg | mask_reg;
               OP_TOGGLE: q_next = q_reg ^ mask_reg;
               default:   q_next = q_reg;
            endcase
            rem_next = rem_reg - (RW+1)'(1);
            if (rem_reg > (RW+1)'(1)) begin
               state_next = GAP;
            end else begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         GAP: begin
            state_next = DRIVE;
            j_next     = op_reg[1] ? mask_reg : '0;
            k_next     = op_reg[0] ? mask_reg : '0;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight command.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         op_reg    <= OP_HOLD;
         mask_reg  <= '0;
         rem_reg   <= '0;
         j_reg     <= '0;
         k_reg     <= '0;
         q_reg     <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         mask_reg  <= mask_next;
         rem_reg   <= rem_next;
         j_reg     <= j_next;
         k_reg     <= k_next;
         q_reg     <= q_next;
         done_reg  <= done_next;
      end
   end

   assign J         = j_reg;
   assign K         = k_reg;
   assign q_model   = q_reg;
   assign done      = done_reg;
   assign busy      = (state_reg != IDLE);
   assign cmd_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed testbench for jk_cmd_driver with hand-computed expectations.
module tb_jk_cmd_driver;

   localparam int N  = 8;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [N-1:0]  cmd_mask = '0;
   logic [RW-1:0] cmd_rep = '0;
   logic [N-1:0]  J, K, q_model;
   logic          busy, done;

   int checks = 0;
   int passed = 0;

   jk_cmd_driver #(.N(N), .RW(RW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_rep(cmd_rep),
      .J(J), .K(K), .busy(busy), .done(done), .q_model(q_model)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] rep);
      cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_rep = rep;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      checks++;
      if ({J, K, q_model, busy, done, cmd_ready} !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_state got J=%h K=%h q=%h busy=%b done=%b rdy=%b exp 00 00 00 0 0 1",
                  J, K, q_model, busy, done, cmd_ready);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      tick();
      $display("reset released: q=%h", q_model);
   endtask

   task automatic test_set();
      issue(2'b10, 8'h0F, 4'h5);   // rep must be ignored for set
      checks++;
      if ({J, K, busy, cmd_ready, q_model} !== {8'h0F, 8'h00, 1'b1, 1'b0, 8'h00})
         $display("FAIL set_drive got J=%h K=%h busy=%b rdy=%b q=%h exp 0f 00 1 0 00",
                  J, K, busy, cmd_ready, q_model);
      else passed++;
      tick();
      checks++;
      if ({J, K, q_model, busy, done, cmd_ready} !== {8'h00, 8'h00, 8'h0F, 1'b0, 1'b1, 1'b1})
         $display("FAIL set_done got J=%h K=%h q=%h busy=%b done=%b rdy=%b exp 00 00 0f 0 1 1",
                  J, K, q_model, busy, done, cmd_ready);
      else passed++;
      tick();
      checks++;
      if ({done, busy} !== 2'b00)
         $display("FAIL set_done_width got done=%b busy=%b exp 0 0", done, busy);
      else passed++;
      $display("set 0x0F: q=%h", q_model);
   endtask

   task automatic test_toggle();
      logic [7:0] qtab [1:5];
      logic [7:0] exp_jk;
      int c;
      qtab[1] = 8'h0F; qtab[2] = 8'h8E; qtab[3] = 8'h8E; qtab[4] = 8'h0F; qtab[5] = 8'h0F;
      issue(2'b11, 8'h81, 4'd2);
      c = 0;
      while (busy && c < 5) begin
         c++;
         exp_jk = (c % 2 == 1) ? 8'h81 : 8'h00;
         checks++;
         if ({J, K, q_model} !== {exp_jk, exp_jk, qtab[c]})
            $display("FAIL toggle_cycle%0d got J=%h K=%h q=%h exp %h %h %h",
                     c, J, K, q_model, exp_jk, exp_jk, qtab[c]);
         else passed++;
         tick();
      end
      checks++;
      if ({c[3:0], busy, done, q_model} !== {4'd5, 1'b0, 1'b1, 8'h8E})
         $display("FAIL toggle_end got cycles=%0d busy=%b done=%b q=%h exp 5 0 1 8e",
                  c, busy, done, q_model);
      else passed++;
      tick();
      $display("toggle 0x81 rep=2: busy cycles=%0d q=%h", c, q_model);
   endtask

   task automatic test_back_to_back();
      issue(2'b01, 8'hF0, 4'd0);
      // Present the next command while busy; it must wait for the done cycle.
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 8'h03; cmd_rep = 4'd7;
      checks++;
      if ({J, K, cmd_ready} !== {8'h00, 8'hF0, 1'b0})
         $display("FAIL b2b_clear_drive got J=%h K=%h rdy=%b exp 00 f0 0", J, K, cmd_ready);
      else passed++;
      tick();
      checks++;
      if ({J, K, done, cmd_ready, q_model} !== {8'h00, 8'h00, 1'b1, 1'b1, 8'h0E})
         $display("FAIL b2b_clear_done got J=%h K=%h done=%b rdy=%b q=%h exp 00 00 1 1 0e",
                  J, K, done, cmd_ready, q_model);
      else passed++;
      tick();
      cmd_valid = 1'b0;
      checks++;
      if ({J, K, busy, done} !== {8'h03, 8'h00, 1'b1, 1'b0})
         $display("FAIL b2b_set_drive got J=%h K=%h busy=%b done=%b exp 03 00 1 0", J, K, busy, done);
      else passed++;
      tick();
      checks++;
      if ({q_model, done, busy} !== {8'h0F, 1'b1, 1'b0})
         $display("FAIL b2b_set_done got q=%h done=%b busy=%b exp 0f 1 0", q_model, done, busy);
      else passed++;
      tick();
      $display("back-to-back clear 0xF0 / set 0x03: q=%h", q_model);
   endtask

   task automatic test_reset_in_gap();
      issue(2'b11, 8'h81, 4'd3);
      tick();
      checks++;
      if ({J, K, busy, q_model} !== {8'h00, 8'h00, 1'b1, 8'h8E})
         $display("FAIL gap_before_reset got J=%h K=%h busy=%b q=%h exp 00 00 1 8e", J, K, busy, q_model);
      else passed++;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({J, K, q_model, busy, done, cmd_ready} !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1})
         $display("FAIL async_reset got J=%h K=%h q=%h busy=%b done=%b rdy=%b exp 00 00 00 0 0 1",
                  J, K, q_model, busy, done, cmd_ready);
      else passed++;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({J, K, busy, done, q_model} !== {8'h00, 8'h00, 1'b0, 1'b0, 8'h00})
            $display("FAIL no_resume_%0d got J=%h K=%h busy=%b done=%b q=%h exp 00 00 0 0 00",
                     i, J, K, busy, done, q_model);
         else passed++;
      end
      $display("reset during gap: q=%h busy=%b", q_model, busy);
   endtask

   task automatic test_hold_clear_empty();
      issue(2'b10, 8'h3C, 4'd0);
      tick();
      issue(2'b00, 8'hFF, 4'd9);
      checks++;
      if ({J, K, busy} !== {8'h00, 8'h00, 1'b1})
         $display("FAIL hold_drive got J=%h K=%h busy=%b exp 00 00 1", J, K, busy);
      else passed++;
      tick();
      checks++;
      if ({J, K, done, q_model} !== {8'h00, 8'h00, 1'b1, 8'h3C})
         $display("FAIL hold_done got J=%h K=%h done=%b q=%h exp 00 00 1 3c", J, K, done, q_model);
      else passed++;
      issue(2'b01, 8'h00, 4'd0);
      checks++;
      if ({J, K, busy} !== {8'h00, 8'h00, 1'b1})
         $display("FAIL clear0_drive got J=%h K=%h busy=%b exp 00 00 1", J, K, busy);
      else passed++;
      tick();
      checks++;
      if ({J, K, done, q_model} !== {8'h00, 8'h00, 1'b1, 8'h3C})
         $display("FAIL clear0_done got J=%h K=%h done=%b q=%h exp 00 00 1 3c", J, K, done, q_model);
      else passed++;
      tick();
      $display("hold 0xFF / clear 0x00: q=%h", q_model);
   endtask

   task automatic test_rep_max();
      int c;
      int pulses;
      issue(2'b11, 8'h01, 4'hF);
      c = 0;
      pulses = 0;
      while (busy && c < 40) begin
         if (J == 8'h01 && K == 8'h01) pulses++;
         c++;
         tick();
      end
      checks++;
      if (c != 31 || pulses != 16)
         $display("FAIL rep_max_count got cycles=%0d pulses=%0d exp 31 16", c, pulses);
      else passed++;
      checks++;
      if ({done, busy, q_model} !== {1'b1, 1'b0, 8'h3C})
         $display("FAIL rep_max_end got done=%b busy=%b q=%h exp 1 0 3c", done, busy, q_model);
      else passed++;
      tick();
      $display("toggle rep=15: busy cycles=%0d pulses=%0d q=%h", c, pulses, q_model);
   endtask

   initial begin
      test_reset();
      test_set();
      test_toggle();
      test_back_to_back();
      test_reset_in_gap();
      test_hold_clear_empty();
      test_rep_max();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
